// File: rtl/data_memory_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds bus widths, the responder state enum and store-size encodings.
package data_memory_pkg;

  localparam int ADDR_WIDTH     = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [2:0] SIZE_BYTE = 3'd1;
  localparam logic [2:0] SIZE_HALF = 3'd2;
  localparam logic [2:0] SIZE_WORD = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BEAT_LO = 2'd1,
    BEAT_HI = 2'd2,
    DONE    = 2'd3
  } data_memory_state_t;

  // Byte-enable pattern for a store size, aligned to byte 0.
  // Illegal sizes give an empty mask so they never touch the RAM.
  function automatic logic [3:0] size_mask(input logic [2:0] size);
    logic [3:0] m;
    m = 4'b0000;
    unique case (1'b1)
      (size == SIZE_BYTE): m = 4'b0001;
      (size == SIZE_HALF): m = 4'b0011;
      (size == SIZE_WORD): m = 4'b1111;
      default:             m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Load/store bus between the memory stage (master) and the responder (slave).
// access_fault exists only when DATA_MEMORY_ACCESS_FAULT_EN is defined.
interface data_memory_responder_if #(
  parameter int ADDR_WIDTH = data_memory_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = data_memory_pkg::DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_activate;
  logic [2:0]            bytes_to_write;
  logic                  write_done;

  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_activate;
  logic [DATA_WIDTH-1:0] fetched_data;
  logic                  fetch_done;

`ifdef DATA_MEMORY_ACCESS_FAULT_EN
  logic                  access_fault;

  modport master (
    output write_addr, write_data, write_activate, bytes_to_write,
    output fetch_addr, fetch_activate,
    input  write_done, fetched_data, fetch_done, access_fault
  );

  modport slave (
    input  write_addr, write_data, write_activate, bytes_to_write,
    input  fetch_addr, fetch_activate,
    output write_done, fetched_data, fetch_done, access_fault
  );
`else
  modport master (
    output write_addr, write_data, write_activate, bytes_to_write,
    output fetch_addr, fetch_activate,
    input  write_done, fetched_data, fetch_done
  );

  modport slave (
    input  write_addr, write_data, write_activate, bytes_to_write,
    input  fetch_addr, fetch_activate,
    output write_done, fetched_data, fetch_done
  );
`endif

endinterface

// File: rtl/data_ram_bank.sv
// Single-port word RAM, DEPTH_WORDS x 32, byte enables, synchronous read.
// Ports: clk, en, we[3:0], addr (word index), wdata, rdata (held when en=0).
module data_ram_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: byte/half/word stores, 32-bit loads at any byte
// address, word-crossing accesses split into LO/HI RAM beats of LATENCY cycles.
// Ports: clk, rst (sync, active-low), bus (data_memory_responder_if.slave).
// Optional: DATA_MEMORY_ACCESS_FAULT_EN adds bus.access_fault.
module data_memory_responder #(
  parameter int ADDR_WIDTH  = data_memory_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH  = data_memory_pkg::DATA_WIDTH,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  data_memory_responder_if.slave  bus
);

  import data_memory_pkg::*;

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

  data_memory_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic                  is_store_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [2:0]            size_q;
  logic                  split_q;
  logic                  fault_q;
  logic [31:0]           lo_word_q;

  logic                  capture;
  logic                  hold;
  logic                  cap_store;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [7:0]            cap_mask;
  logic                  cap_split;
  logic                  cap_fault;

  logic          beat_last;
  logic          in_hi;
  logic [IW-1:0] lo_idx;
  logic [7:0]    st_mask;
  logic [63:0]   st_data;
  logic [31:0]   load_word;

  logic          ram_en;
  logic [3:0]    ram_we;
  logic [IW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  // Request decode at capture time; store wins over load.
  always_comb begin
    cap_store = bus.write_activate;
    cap_addr  = cap_store ? bus.write_addr : bus.fetch_addr;
    cap_mask  = {4'b0000, size_mask(bus.bytes_to_write)}
                << cap_addr[1:0];
`ifdef DATA_MEMORY_ACCESS_FAULT_EN
    cap_fault = 1'b0;
    if ((cap_addr >> (IW + 2)) != '0) cap_fault = 1'b1;
    if (cap_store) begin
      if (size_mask(bus.bytes_to_write) == 4'b0000) cap_fault = 1'b1;
      if (bus.bytes_to_write == SIZE_HALF && cap_addr[0])
        cap_fault = 1'b1;
      if (bus.bytes_to_write == SIZE_WORD && cap_addr[1:0] != 2'b00)
        cap_fault = 1'b1;
    end else if (cap_addr[1:0] != 2'b00) begin
      cap_fault = 1'b1;
    end
`else
    cap_fault = 1'b0;
`endif
    if (cap_store) cap_split = |cap_mask[7:4];
    else           cap_split = (cap_addr[1:0] != 2'b00);
    if (cap_fault) cap_split = 1'b0;
  end

  // DONE is held only while the initiator keeps presenting the same request.
  always_comb begin
    if (is_store_q) begin
      hold = bus.write_activate
          && bus.write_addr == addr_q
          && bus.bytes_to_write == size_q
          && bus.write_data == data_q;
    end else begin
      hold = bus.fetch_activate && bus.fetch_addr == addr_q;
    end
  end

  assign beat_last = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.write_activate || bus.fetch_activate) begin
          capture = 1'b1;
          state_d = BEAT_LO;
          cnt_d   = '0;
        end
      end
      BEAT_LO: begin
        if (beat_last) begin
          cnt_d   = '0;
          state_d = split_q ? BEAT_HI : DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BEAT_HI: begin
        if (beat_last) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (!hold) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      is_store_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      size_q     <= '0;
      split_q    <= 1'b0;
      fault_q    <= 1'b0;
      lo_word_q  <= '0;
    end else begin
      if (capture) begin
        is_store_q <= cap_store;
        addr_q     <= cap_addr;
        data_q     <= bus.write_data;
        size_q     <= bus.bytes_to_write;
        split_q    <= cap_split;
        fault_q    <= cap_fault;
      end
      // RAM output still shows the LO word until the HI read lands.
      if (state_q == BEAT_HI && beat_last) lo_word_q <= ram_rdata;
    end
  end

  // Store lanes rotated into a two-word window; upper half is the HI beat.
  assign in_hi   = (state_q == BEAT_HI);
  assign lo_idx  = addr_q[2 +: IW];
  assign st_mask = {4'b0000, size_mask(size_q)} << addr_q[1:0];
  assign st_data = {32'b0, data_q} << {addr_q[1:0], 3'b000};

  // Gated by rst so a beat ending on a reset edge never reaches the RAM.
  assign ram_en = rst && !fault_q && beat_last
               && (state_q == BEAT_LO || in_hi);
  assign ram_we = !is_store_q ? 4'b0000
                : in_hi       ? st_mask[7:4]
                :               st_mask[3:0];
  assign ram_addr  = in_hi ? lo_idx + 1'b1 : lo_idx;
  assign ram_wdata = in_hi ? st_data[63:32] : st_data[31:0];

  data_ram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign load_word = split_q
    ? 32'({ram_rdata, lo_word_q} >> {addr_q[1:0], 3'b000})
    : ram_rdata;

  assign bus.write_done   = (state_q == DONE) && is_store_q;
  assign bus.fetch_done   = (state_q == DONE) && !is_store_q;
  assign bus.fetched_data = (bus.fetch_done && !fault_q)
                          ? load_word : '0;
`ifdef DATA_MEMORY_ACCESS_FAULT_EN
  assign bus.access_fault = (state_q == DONE) && fault_q;
`endif

endmodule
